// File: rtl/eth_arb_pkg.sv
// Shared types and defaults for the Ethernet MAC memory-port arbiter.
//
// Contents:
//   arb_state_e  - APB sequencer state (IDLE, SETUP, ACCESS)
//   DefAw/DefDw  - default address / data widths
//   tcnt_width() - width of the ACCESS watchdog counter for a given limit
//
// The watchdog is only built when ETH_ARB_TIMEOUT_EN is defined.
package eth_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } arb_state_e;

    localparam int unsigned DefAw = 32;
    localparam int unsigned DefDw = 32;

    // Counter must be able to hold the value TIMEOUT_CYC itself.
    function automatic int unsigned tcnt_width(input int unsigned cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker.
//
// Searches i_req (with i_mask bits excluded) starting at i_last+1 and wrapping,
// and returns the first hit.
//
// Ports:
//   i_req    [NREQ] request vector
//   i_mask   [NREQ] requests to ignore (set bits never win)
//   i_last   [IW]   index of the previous winner
//   o_onehot [NREQ] one-hot winner
//   o_index  [IW]   binary winner index
//   o_any           a winner exists
module eth_rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_index,
    output logic            o_any
);

    int unsigned w_cand;

    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        w_cand   = 0;
        // Offset NREQ wraps back to i_last itself, which is checked last.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            w_cand = (32'(i_last) + off) % NREQ;
            if (!o_any && i_req[IW'(w_cand)] && !i_mask[IW'(w_cand)]) begin
                o_any                 = 1'b1;
                o_onehot[IW'(w_cand)] = 1'b1;
                o_index               = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/eth_mem_arbiter.sv
// Round-robin arbiter placing NREQ DMA requesters onto a single APB master port.
//
// A registered IDLE/SETUP/ACCESS sequencer drives the APB signals. On completion
// the granted requester gets a one-cycle done_o pulse with read data on rdata_o
// (zero for writes). A pending request from another requester is launched
// straight into SETUP on the completing edge, so alternating requesters see two
// cycles per transfer.
//
// Ports:
//   pclk_i, prstn_i           clock, asynchronous active-low reset
//   req_i/addr_i/wdata_i/write_i  per-requester request and flattened payload
//   gnt_o, done_o, err_o      per-requester grant, completion, timeout pulse
//   rdata_o, busy_o           completion read data, sequencer not idle
//   m_p*                      APB master port
//
// Build option: ETH_ARB_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT_CYC cycles
// that ends the transfer with done_o and err_o; without it err_o is tied low.
module eth_mem_arbiter
    import eth_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned AW          = DefAw,
    parameter int unsigned DW          = DefDw,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                 pclk_i,
    input  logic                 prstn_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    input  logic [NREQ*DW-1:0]   wdata_i,
    input  logic [NREQ-1:0]      write_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    output logic [AW-1:0]        m_paddr_o,
    output logic [DW-1:0]        m_pwdata_o,
    output logic                 m_psel_o,
    output logic                 m_penable_o,
    output logic                 m_pwrite_o,
    input  logic [DW-1:0]        m_prdata_i,
    input  logic                 m_pready_i
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_e        r_state, w_state_nxt;
    logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
    logic [IW-1:0]     r_widx, w_widx_nxt;
    logic [IW-1:0]     r_last, w_last_nxt;
    logic [NREQ-1:0]   r_done, w_done_nxt;
    logic [DW-1:0]     r_rdata, w_rdata_nxt;
    logic              r_busy, w_busy_nxt;
    logic [AW-1:0]     r_paddr, w_paddr_nxt;
    logic [DW-1:0]     r_pwdata, w_pwdata_nxt;
    logic              r_pwrite, w_pwrite_nxt;
    logic              r_psel, w_psel_nxt;
    logic              r_penable, w_penable_nxt;

`ifdef ETH_ARB_TIMEOUT_EN
    localparam int unsigned TCW = tcnt_width(TIMEOUT_CYC);
    logic [NREQ-1:0]   r_err, w_err_nxt;
    logic [TCW-1:0]    r_tcnt, w_tcnt_nxt;
`endif

    // Picker inputs: during ACCESS the completing requester is masked (its req
    // is still high on the completing edge) and the search starts after it.
    logic              w_in_access;
    logic [NREQ-1:0]   w_mask;
    logic [IW-1:0]     w_search_last;
    logic [NREQ-1:0]   w_pick_oh;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;

    assign w_in_access   = (r_state == StAccess);
    assign w_mask        = w_in_access ? r_gnt : '0;
    assign w_search_last = w_in_access ? r_widx : r_last;

    eth_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req    (req_i),
        .i_mask   (w_mask),
        .i_last   (w_search_last),
        .o_onehot (w_pick_oh),
        .o_index  (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Payload of the picked requester.
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_write;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_oh[i]) begin
                w_sel_addr  = addr_i[i*AW +: AW];
                w_sel_wdata = wdata_i[i*DW +: DW];
                w_sel_write = write_i[i];
            end
        end
    end

    logic w_launch;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_widx_nxt    = r_widx;
        w_last_nxt    = r_last;
        w_done_nxt    = '0;
        w_rdata_nxt   = '0;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_pwrite_nxt  = r_pwrite;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_launch      = 1'b0;
`ifdef ETH_ARB_TIMEOUT_EN
        w_err_nxt     = '0;
        w_tcnt_nxt    = r_tcnt;
`endif

        case (r_state)
            StIdle: begin
                w_launch = w_pick_any;
            end
            StSetup: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = StAccess;
`ifdef ETH_ARB_TIMEOUT_EN
                w_tcnt_nxt    = '0;
`endif
            end
            StAccess: begin
                if (m_pready_i) begin
                    w_done_nxt  = r_gnt;
                    w_rdata_nxt = r_pwrite ? '0 : m_prdata_i;
                    w_last_nxt  = r_widx;
                    if (w_pick_any) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt   = StIdle;
                        w_gnt_nxt     = '0;
                        w_psel_nxt    = 1'b0;
                        w_penable_nxt = 1'b0;
                    end
                end
`ifdef ETH_ARB_TIMEOUT_EN
                else if (r_tcnt == TCW'(TIMEOUT_CYC - 1)) begin
                    // Last permitted ACCESS cycle without pready: abandon.
                    w_done_nxt    = r_gnt;
                    w_err_nxt     = r_gnt;
                    w_last_nxt    = r_widx;
                    w_state_nxt   = StIdle;
                    w_gnt_nxt     = '0;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCW'(1);
                end
`endif
            end
            default: begin
                w_state_nxt   = StIdle;
                w_gnt_nxt     = '0;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase

        if (w_launch) begin
            w_state_nxt   = StSetup;
            w_gnt_nxt     = w_pick_oh;
            w_widx_nxt    = w_pick_idx;
            w_paddr_nxt   = w_sel_addr;
            w_pwdata_nxt  = w_sel_wdata;
            w_pwrite_nxt  = w_sel_write;
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_widx    <= '0;
            r_last    <= IW'(NREQ - 1);
            r_done    <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_widx    <= w_widx_nxt;
            r_last    <= w_last_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_busy    <= w_busy_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
        end
    end

`ifdef ETH_ARB_TIMEOUT_EN
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            r_err  <= '0;
            r_tcnt <= '0;
        end else begin
            r_err  <= w_err_nxt;
            r_tcnt <= w_tcnt_nxt;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = '0;
`endif

    assign gnt_o       = r_gnt;
    assign done_o      = r_done;
    assign rdata_o     = r_rdata;
    assign busy_o      = r_busy;
    assign m_paddr_o   = r_paddr;
    assign m_pwdata_o  = r_pwdata;
    assign m_pwrite_o  = r_pwrite;
    assign m_psel_o    = r_psel;
    assign m_penable_o = r_penable;

endmodule

// File: tb/tb_eth_mem_arbiter.sv
// Self-checking bench for eth_mem_arbiter (NREQ=2, 32-bit, TIMEOUT_CYC=8).
// Single-transfer vectors come from a table; back-to-back fairness, reset
// during ACCESS and the optional watchdog are hand sequences; a random phase
// is checked against a round-robin / memory reference model.
module tb_eth_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 8;

    logic                 pclk  = 1'b0;
    logic                 prstn = 1'b0;
    logic [NREQ-1:0]      req   = '0;
    logic [NREQ*AW-1:0]   addr  = '0;
    logic [NREQ*DW-1:0]   wdata = '0;
    logic [NREQ-1:0]      write = '0;
    logic [NREQ-1:0]      gnt, done, err;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic [AW-1:0]        m_paddr;
    logic [DW-1:0]        m_pwdata;
    logic                 m_psel, m_penable, m_pwrite;
    logic [DW-1:0]        m_prdata = '0;
    logic                 m_pready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    eth_mem_arbiter #(
        .NREQ        (NREQ),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk_i      (pclk),
        .prstn_i     (prstn),
        .req_i       (req),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .write_i     (write),
        .gnt_o       (gnt),
        .done_o      (done),
        .err_o       (err),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .m_paddr_o   (m_paddr),
        .m_pwdata_o  (m_pwdata),
        .m_psel_o    (m_psel),
        .m_penable_o (m_penable),
        .m_pwrite_o  (m_pwrite),
        .m_prdata_i  (m_prdata),
        .m_pready_i  (m_pready)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- APB slave: memory with configurable wait states -----
    logic [31:0] mem [logic [31:0]];
    int          slv_waits = 0;
    bit          slv_rand  = 1'b0;
    int          acc_cnt   = 0;
    int          cur_waits = 0;

    always @(negedge pclk) begin
        if (m_psel && m_penable) begin
            if (acc_cnt == 0) cur_waits = slv_rand ? int'($urandom_range(0, 2)) : slv_waits;
            m_pready = (acc_cnt >= cur_waits);
            if (m_pready && !m_pwrite)
                m_prdata = mem.exists(m_paddr) ? mem[m_paddr] : dflt(m_paddr);
            else
                m_prdata = $urandom;
            if (m_pready && m_pwrite) mem[m_paddr] = m_pwdata;
            acc_cnt++;
        end else begin
            acc_cnt  = 0;
            m_pready = 1'b0;
            m_prdata = $urandom;
        end
    end

    // ---------------- helpers ---------------------------------------------
    task automatic set_req(input int i, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = wd;
        write[i]          = wr;
        req[i]            = 1'b1;
    endtask

    task automatic apply_reset();
        req   = '0;
        prstn = 1'b0;
        repeat (2) @(negedge pclk);
        prstn = 1'b1;
    endtask

    typedef struct {
        int          who;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        logic [31:0] rd;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_psel;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int n, input vec_t v);
        int   psel_cnt = 0;
        bit   seen     = 1'b0;
        bit   stable   = 1'b1;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[v.who] = 1'b1;
        slv_waits = v.waits;
        if (!v.wr) mem[v.a] = v.rd;
        set_req(v.who, v.a, v.wr, v.wd);
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(negedge pclk);
            if (m_psel) begin
                psel_cnt++;
                if (psel_cnt == 1) check($sformatf("v%0d_setup_penable", n), m_penable, 1'b0);
                if (m_paddr !== v.a || m_pwrite !== v.wr || gnt !== oh ||
                    (v.wr && m_pwdata !== v.wd)) stable = 1'b0;
            end
            if (done != '0) begin
                seen = 1'b1;
                check($sformatf("v%0d_done", n), done, oh);
                check($sformatf("v%0d_latency", n), cyc, v.exp_lat);
                check($sformatf("v%0d_rdata", n), rdata, v.exp_rdata);
                req[v.who] = 1'b0;
            end
        end
        check($sformatf("v%0d_seen_done", n), seen, 1'b1);
        check($sformatf("v%0d_psel_cycles", n), psel_cnt, v.exp_psel);
        check($sformatf("v%0d_apb_stable", n), stable, 1'b1);
        if (v.wr) check($sformatf("v%0d_mem_written", n), mem[v.a], v.wd);
        @(negedge pclk);
        check($sformatf("v%0d_idle_after", n), {busy, m_psel}, 2'b00);
    endtask

    // ---------------- random-phase model state ----------------------------
    logic [31:0]     model_mem [logic [31:0]];
    logic [31:0]     ra  [NREQ];
    logic            rw  [NREQ];
    logic [31:0]     rwd [NREQ];
    logic [NREQ-1:0] active;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              ndone;
        int              last_cyc;
        int              cnt [NREQ];
        bit              seen;
        int              acc;
        int              model_last;
        logic [NREQ-1:0] prev_gnt, cur_req, pend, jd;
        logic [31:0]     exp_rd;
        int              d, w, j;

        vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,         0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 2};
        vecs[1] = '{1, 1'b1, 32'h0000_2004, 32'h1234_5678, 3, 32'h0,         6, 32'h0,         5};
        vecs[2] = '{0, 1'b1, 32'h0000_1008, 32'hA5A5_5A5A, 0, 32'h0,         3, 32'h0,         2};
        vecs[3] = '{1, 1'b0, 32'h0000_3000, 32'h0,         2, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 4};
        vecs[4] = '{0, 1'b0, 32'h0000_FFFC, 32'h0,         1, 32'h0000_0001, 4, 32'h0000_0001, 3};
        vecs[5] = '{1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h0,         4, 32'h0,         3};

        // Reset values.
        @(negedge pclk);
        check("rst_psel", m_psel, 1'b0);
        check("rst_penable", m_penable, 1'b0);
        check("rst_pwrite", m_pwrite, 1'b0);
        check("rst_paddr", m_paddr, 32'h0);
        check("rst_pwdata", m_pwdata, 32'h0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        @(negedge pclk);
        prstn = 1'b1;
        @(negedge pclk);

        // Table-driven single transfers.
        for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

        // Both requesters continuously active, 4 transfers each.
        apply_reset();
        slv_waits = 0;
        set_req(0, 32'h0000_3000, 1'b0, 32'h0);
        set_req(1, 32'h0000_3100, 1'b0, 32'h0);
        ndone = 0; last_cyc = 0; cnt[0] = 0; cnt[1] = 0;
        for (int cyc = 1; cyc <= 40 && ndone < 8; cyc++) begin
            @(negedge pclk);
            if (done != '0) begin
                d = done[1] ? 1 : 0;
                check($sformatf("rr_order_%0d", ndone), done, 2'b01 << (ndone % 2));
                if (ndone == 0) check("rr_first_latency", cyc, 3);
                else check($sformatf("rr_spacing_%0d", ndone), cyc - last_cyc, 2);
                if (ndone < 7) check($sformatf("rr_b2b_setup_%0d", ndone), {m_psel, m_penable}, 2'b10);
                cnt[d]++;
                if (cnt[d] == 4) req[d] = 1'b0;
                last_cyc = cyc;
                ndone++;
            end
        end
        check("rr_total_done", ndone, 8);
        @(negedge pclk);
        check("rr_idle_after", busy, 1'b0);

        // Reset during ACCESS.
        apply_reset();
        run_vec(6, vecs[0]);
        slv_waits = 50;
        set_req(0, 32'h0000_6000, 1'b0, 32'h0);
        set_req(1, 32'h0000_6100, 1'b0, 32'h0);
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge pclk);
            if (m_penable) seen = 1'b1;
        end
        check("mid_reached_access", seen, 1'b1);
        check("mid_rr_after_req0", gnt, 2'b10);
        #2 prstn = 1'b0;
        #1 check("mid_async_clear",
                 {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, gnt, done, err, rdata, busy},
                 128'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            check("mid_no_done_in_reset", {done, m_psel}, 3'b000);
        end
        slv_waits = 0;
        prstn = 1'b1;
        @(negedge pclk);
        check("mid_first_after_reset", gnt, 2'b01);
        for (int cyc = 0; cyc < 40 && (req != '0 || busy); cyc++) begin
            @(negedge pclk);
            req = req & ~done;
        end
        check("mid_drained", {req, busy}, 3'b000);

`ifdef ETH_ARB_TIMEOUT_EN
        // Watchdog: pready never arrives for requester 0.
        apply_reset();
        slv_waits = 1000;
        set_req(0, 32'h0000_5000, 1'b0, 32'h0);
        set_req(1, 32'h0000_5100, 1'b0, 32'h0);
        acc = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge pclk);
            if (m_psel && m_penable) acc++;
            if (done != '0) begin
                seen = 1'b1;
                check("to_done", done, 2'b01);
                check("to_err", err, 2'b01);
                check("to_access_cycles", acc, TO);
                check("to_rdata", rdata, 32'h0);
                check("to_psel_drop", {m_psel, m_penable}, 2'b00);
                req[0] = 1'b0;
                slv_waits = 0;
            end
        end
        check("to_seen", seen, 1'b1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge pclk);
            if (done != '0) begin
                seen = 1'b1;
                check("to_next_done", done, 2'b10);
                check("to_next_err", err, 2'b00);
                req[1] = 1'b0;
            end
        end
        check("to_next_seen", seen, 1'b1);
`endif

        // Random traffic against the reference model.
        apply_reset();
        slv_rand   = 1'b1;
        model_last = NREQ - 1;
        prev_gnt   = '0;
        active     = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge pclk);
            cur_req = req;   // what the DUT sampled on the last edge
            jd = '0;
            if (done != '0) begin
                check("rnd_done_onehot", $onehot(done), 1'b1);
                d = done[1] ? 1 : 0;
                check("rnd_done_owner", active[d], 1'b1);
                check("rnd_err", err, 2'b00);
                if (rw[d]) begin
                    exp_rd = 32'h0;
                    model_mem[ra[d]] = rwd[d];
                end else begin
                    exp_rd = model_rd(ra[d]);
                end
                check("rnd_rdata", rdata, exp_rd);
                model_last = d;
                active[d]  = 1'b0;
                req[d]     = 1'b0;
                jd[d]      = 1'b1;
            end
            if (gnt != '0 && (prev_gnt == '0 || done != '0)) begin
                pend = cur_req & ~done;
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    j = (model_last + k) % NREQ;
                    if (w < 0 && pend[j]) w = j;
                end
                if (w < 0) begin
                    check("rnd_spurious_gnt", gnt, 2'b00);
                end else begin
                    check("rnd_gnt", gnt, 2'b01 << w);
                    check("rnd_paddr", m_paddr, ra[w]);
                    check("rnd_pwrite", m_pwrite, rw[w]);
                    if (rw[w]) check("rnd_pwdata", m_pwdata, rwd[w]);
                    check("rnd_setup_phase", {m_psel, m_penable}, 2'b10);
                end
            end
            prev_gnt = gnt;
            if (cyc < 600) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!active[i] && !jd[i] && $urandom_range(0, 2) == 0) begin
                        ra[i]  = 32'h0000_4000 + 32'(4 * $urandom_range(0, 7));
                        rw[i]  = 1'($urandom_range(0, 1));
                        rwd[i] = $urandom;
                        set_req(i, ra[i], rw[i], rwd[i]);
                        active[i] = 1'b1;
                    end
                end
            end
        end
        check("rnd_drained", {active, busy}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_mem_arbiter.md
# eth_mem_arbiter

Arbitrates N internal requesters (TX descriptor/data fetch, RX data/status writeback, and similar) onto the Ethernet MAC's single APB master memory port (m_paddr_o … m_pready_i). It runs a registered APB SETUP/ACCESS sequencer, selects the next requester round-robin, and returns read data and a one-cycle completion pulse to the granted requester. It sits between the MAC's DMA engines and the system memory bus, in the pclk_i domain.

## Interface
Parameters:
- NREQ, 2: number of requesters (2–8)
- AW, 32: address width
- DW, 32: data width
- TIMEOUT_CYC, 256: ACCESS-phase watchdog limit in cycles; used only with ETH_ARB_TIMEOUT_EN

Ports:
- pclk_i  in  1  clock
- prstn_i  in  1  reset; asynchronous, active-low
- req_i  in  NREQ  per-requester request, held high until that requester's done_o
- addr_i  in  NREQ*AW  flattened addresses, slice i belongs to requester i
- wdata_i  in  NREQ*DW  flattened write data
- write_i  in  NREQ  1 = write, 0 = read
- gnt_o  out  NREQ  one-hot grant, high from SETUP through ACCESS
- done_o  out  NREQ  one-cycle completion pulse
- err_o  out  NREQ  one-cycle timeout pulse, coincident with done_o
- rdata_o  out  DW  read data, valid while done_o is high
- busy_o  out  1  high whenever state ≠ IDLE
- m_paddr_o, m_pwdata_o  out  AW/DW  APB address and write data
- m_psel_o, m_penable_o, m_pwrite_o  out  1  APB control
- m_prdata_i  in  DW  APB read data
- m_pready_i  in  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If any req_i is high, pick the winner round-robin, searching from last_gnt+1 upward with wrap.
  - Latch the winner's addr, wdata and write onto m_paddr_o, m_pwdata_o and m_pwrite_o.
  - Set m_psel_o=1, m_penable_o=0, gnt_o=onehot(winner), and move to SETUP.
- SETUP: set m_penable_o=1 and move to ACCESS. This takes exactly one cycle.
- ACCESS, m_pready_i sampled high:
  - Pulse done_o[winner] for one cycle.
  - rdata_o = m_prdata_i for a read, 0 for a write.
  - last_gnt = winner.
- ACCESS exit (back-to-back):
  - Mask the completing requester's req bit, since it is still high on this edge.
  - If another req is pending, go directly to SETUP with the new winner: psel stays 1, penable drops to 0, new address and data are driven.
  - Otherwise go to IDLE and drive psel, penable and gnt to 0.
- ACCESS, m_pready_i low: hold all APB outputs stable.
- Requesters must keep addr, wdata and write stable while req is high. The arbiter ignores any change after latching.
- Arbitration is fair: with all requesters continuously active, grants rotate 0,1,…,NREQ-1,0.
- Deasserting req_i while granted is illegal and is ignored; the transfer completes.

## Timing
- Reset (async assert) clears these to 0:
  - m_psel_o, m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o
  - gnt_o, done_o, err_o, rdata_o, busy_o
  - state = IDLE, last_gnt = NREQ-1, so requester 0 wins first.
- Reset mid-transfer: the APB transfer is abandoned immediately and no done_o is issued.
- Zero-wait read latency: req sampled at edge k → psel after edge k → penable after k+1 → done_o and rdata_o after k+2. Each wait state adds 1 cycle.
- Sustained throughput: 2 cycles per transfer with alternating requesters. A single requester gets 3 cycles per transfer (IDLE gap).
- Simultaneous requests in IDLE: round-robin order decides the winner. The losers wait, with gnt low.

## Configuration
- Macro: ETH_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts ACCESS cycles.
  - If pready has not been seen after TIMEOUT_CYC cycles, drop psel/penable and pulse done_o[winner] together with err_o[winner], with rdata_o=0.
  - Then return to IDLE; last_gnt is updated as normal.
  - The counter clears on entry to each ACCESS.
- Undefined: there is no counter, ACCESS waits indefinitely, and err_o is tied to 0.

## Structure
- Package eth_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS)
  - default AW/DW localparams
  - TIMEOUT counter width = $clog2(TIMEOUT_CYC+1)
- Sub-module eth_rr_pick: combinational one-hot round-robin picker.
  - Inputs: req, mask, last_gnt.
  - Outputs: onehot, index, any.
  - Instantiated once.

## Test plan
- Single read, req_i=2'b01, addr 0x1000, pready high on the first ACCESS cycle, prdata 0xDEADBEEF → done_o[0] 3 cycles after req; rdata_o=0xDEADBEEF; psel high for 2 cycles.
- Both requesters continuously active, 4 transfers each → grant order 0,1,0,1…; back-to-back SETUP with no IDLE gap; 2 cycles per transfer.
- Write from requester 1, addr 0x2004, wdata 0x12345678, 3 wait states → APB signals stable for 5 cycles; done_o[1] after the pready edge; rdata_o=0.
- prstn_i asserted during ACCESS → all outputs 0 immediately; no done_o; after release, requester 0 wins first.
- With ETH_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, pready held low → done_o[0] and err_o[0] pulse after 8 ACCESS cycles; psel drops; the next requester is served.
